life_engine: RTL



---
 rtl/life_pkg.sv | 30 +++
 rtl/life_row_next.sv | 67 ++++++
 rtl/life_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life engine.
//
// Contents:
//   state_t   engine state encoding (INI, SET, RUN, CALC, STOP)
//   ROW_W     row index width for the default 16-row board
//   POP_W     per-row birth/death popcount width for the default 16-column board
//   b4()      zero-extends a cell bit to a 4-bit neighbour-count operand
//
// Edge behaviour is selected by the LIFE_TORUS_EN macro in the files that use this package.

package life_pkg;

    localparam int ROWS_DEF = 16;
    localparam int COLS_DEF = 16;
    localparam int ROW_W    = $clog2(ROWS_DEF);
    localparam int POP_W    = $clog2(COLS_DEF + 1);

    typedef enum logic [2:0] {
        ST_INI  = 3'd0,
        ST_SET  = 3'd1,
        ST_RUN  = 3'd2,
        ST_CALC = 3'd3,
        ST_STOP = 3'd4
    } state_t;

    function automatic logic [3:0] b4(input logic b);
        return {3'b000, b};
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation calculator for one board row.
//
// Ports:
//   row_above  row k-1 (already resolved to dead or wrapped by the caller)
//   row_cur    row k
//   row_below  row k+1 (already resolved to dead or wrapped by the caller)
//   row_next   row k of the next generation
//   births     number of dead->live cells in this row
//   deaths     number of live->dead cells in this row
//
// LIFE_TORUS_EN defined: column -1 is column COLS-1 and column COLS is column 0.
// LIFE_TORUS_EN undefined: cells beyond the left/right edges are dead.

module life_row_next
    import life_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int PW   = POP_W
) (
    input  logic [COLS-1:0] row_above,
    input  logic [COLS-1:0] row_cur,
    input  logic [COLS-1:0] row_below,
    output logic [COLS-1:0] row_next,
    output logic [PW-1:0]   births,
    output logic [PW-1:0]   deaths
);

    // Rows padded with one ghost column each side: bit 0 is column -1,
    // bit c+1 is column c, bit COLS+1 is column COLS.
    logic [COLS+1:0] ax, cx, bx;

    always_comb begin
`ifdef LIFE_TORUS_EN
        ax = {row_above[0], row_above, row_above[COLS-1]};
        cx = {row_cur[0],   row_cur,   row_cur[COLS-1]};
        bx = {row_below[0], row_below, row_below[COLS-1]};
`else
        ax = {1'b0, row_above, 1'b0};
        cx = {1'b0, row_cur,   1'b0};
        bx = {1'b0, row_below, 1'b0};
`endif
    end

    logic [3:0] nbr;
    logic       alive;
    logic       nxt;

    always_comb begin
        row_next = '0;
        births   = '0;
        deaths   = '0;
        nbr      = '0;
        alive    = 1'b0;
        nxt      = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            nbr = b4(ax[c]) + b4(ax[c+1]) + b4(ax[c+2])
                + b4(cx[c])               + b4(cx[c+2])
                + b4(bx[c]) + b4(bx[c+1]) + b4(bx[c+2]);
            alive = cx[c+1];
            nxt   = (nbr == 4'd3) || (alive && (nbr == 4'd2));
            row_next[c] = nxt;
            if (nxt && !alive) births = births + PW'(1);
            if (!nxt && alive) deaths = deaths + PW'(1);
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: ROWS x COLS board, row-wise edits while idle,
// one row per clock into a shadow board, atomic commit.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   run_toggle          pulse: SET/STOP -> RUN, RUN -> STOP (latched during CALC)
//   step                pulse: one generation from SET/STOP
//   tick                generation-rate enable, used only in RUN
//   clear               pulse: zero board, counters and stable in SET/STOP
//   wr_en/wr_row/wr_data  row write in SET/STOP; rows >= ROWS ignored
//   board               row r at [r*COLS +: COLS]
//   busy                high while in CALC
//   done                one-cycle pulse after each commit
//   stable              last commit equalled its predecessor
//   generation_cnt, birth_cnt, death_cnt  wrapping counters
//
// LIFE_TORUS_EN defined: board edges wrap in both directions.
//
// state | meaning
// INI   | one cycle after reset, edits ignored
// SET   | idle after reset, edits allowed
// RUN   | free running, each tick starts a generation
// CALC  | row k of the shadow computed at E(k+1), commit at E(ROWS+1)
// STOP  | idle after a generation or a stop, edits allowed

module life_engine
    import life_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run_toggle,
    input  logic                     step,
    input  logic                     tick,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [COLS-1:0]          wr_data,
    output logic [ROWS*COLS-1:0]     board,
    output logic                     busy,
    output logic                     done,
    output logic                     stable,
    output logic [CNT_W-1:0]         generation_cnt,
    output logic [CNT_W-1:0]         birth_cnt,
    output logic [CNT_W-1:0]         death_cnt
);

    localparam int R_W = $clog2(ROWS);
    localparam int P_W = $clog2(COLS + 1);
    localparam int I_W = $clog2(ROWS + 1);

    state_t state_q, state_d;

    logic [ROWS-1:0][COLS-1:0] board_q, shadow_q;
    logic [I_W-1:0]            row_idx;
    logic                      from_run;
    logic                      stop_req;
    logic [CNT_W-1:0]          calc_births, calc_deaths;

    logic edit_ok, do_clear, do_write, row_phase, commit, stable_d;

    logic [R_W-1:0]  row_cur, row_up, row_dn;
    logic [COLS-1:0] above, below, row_next;
    logic [P_W-1:0]  row_births, row_deaths;

    assign board    = board_q;
    assign stable_d = (shadow_q == board_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_INI;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INI: state_d = ST_SET;
            ST_SET, ST_STOP: begin
                if (clear || wr_en) state_d = state_q;
                else if (step)      state_d = ST_CALC;
                else if (run_toggle) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (run_toggle) state_d = ST_STOP;
                else if (tick)  state_d = ST_CALC;
            end
            ST_CALC: begin
                if (commit) begin
                    // A toggle on the commit edge counts the same as one latched earlier.
                    if (!from_run || stop_req || run_toggle || stable_d) state_d = ST_STOP;
                    else                                                 state_d = ST_RUN;
                end
            end
            default: state_d = ST_INI;
        endcase
    end

    // ---------------- FSM: outputs / datapath enables ----------------
    always_comb begin
        busy      = (state_q == ST_CALC);
        edit_ok   = (state_q == ST_SET) || (state_q == ST_STOP);
        do_clear  = edit_ok && clear;
        do_write  = edit_ok && !clear && wr_en && (int'(wr_row) < ROWS);
        row_phase = busy && (int'(row_idx) < ROWS);
        commit    = busy && (int'(row_idx) == ROWS);
    end

    // ---------------- row neighbourhood ----------------
    always_comb begin
        row_cur = row_idx[R_W-1:0];
        row_up  = (row_cur == '0) ? R_W'(ROWS - 1) : row_cur - R_W'(1);
        row_dn  = (row_cur == R_W'(ROWS - 1)) ? '0 : row_cur + R_W'(1);
`ifdef LIFE_TORUS_EN
        above = board_q[row_up];
        below = board_q[row_dn];
`else
        above = (row_cur == '0) ? '0 : board_q[row_up];
        below = (row_cur == R_W'(ROWS - 1)) ? '0 : board_q[row_dn];
`endif
    end

    life_row_next #(
        .COLS (COLS),
        .PW   (P_W)
    ) u_row_next (
        .row_above (above),
        .row_cur   (board_q[row_cur]),
        .row_below (below),
        .row_next  (row_next),
        .births    (row_births),
        .deaths    (row_deaths)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            board_q        <= '0;
            shadow_q       <= '0;
            row_idx        <= '0;
            from_run       <= 1'b0;
            stop_req       <= 1'b0;
            calc_births    <= '0;
            calc_deaths    <= '0;
            generation_cnt <= '0;
            birth_cnt      <= '0;
            death_cnt      <= '0;
            done           <= 1'b0;
            stable         <= 1'b0;
        end else begin
            done <= commit;

            if (do_clear) begin
                board_q        <= '0;
                generation_cnt <= '0;
                birth_cnt      <= '0;
                death_cnt      <= '0;
                stable         <= 1'b0;
            end else if (do_write) begin
                board_q[wr_row] <= wr_data;
            end

            if ((state_q != ST_CALC) && (state_d == ST_CALC)) begin
                row_idx     <= '0;
                calc_births <= '0;
                calc_deaths <= '0;
                from_run    <= (state_q == ST_RUN);
                stop_req    <= 1'b0;
            end

            if (busy && run_toggle) stop_req <= 1'b1;

            if (row_phase) begin
                shadow_q[row_cur] <= row_next;
                calc_births       <= calc_births + CNT_W'(row_births);
                calc_deaths       <= calc_deaths + CNT_W'(row_deaths);
                row_idx           <= row_idx + I_W'(1);
            end

            if (commit) begin
                board_q        <= shadow_q;
                generation_cnt <= generation_cnt + CNT_W'(1);
                birth_cnt      <= birth_cnt + calc_births;
                death_cnt      <= death_cnt + calc_deaths;
                stable         <= stable_d;
            end
        end
    end

endmodule
